jk_updown_counter: RTL and testbench



---
 rtl/jk_updown_counter.sv | 65 ++++++
 tb/tb_jk_updown_counter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_updown_counter.sv
// Loadable modulo-MOD up/down counter built from JK-style hold/toggle control.
// TC is combinational for same-cycle cascading; Q, Q_N and OVF are registered.
module jk_updown_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 16,
  parameter bit SAT   = 1'b0
) (
  input  logic             CP,
  input  logic             RD_N,
  input  logic             LD_N,
  input  logic             EN,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_N,
  output logic             TC,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;

  // Out-of-range load values clamp to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
    return ({1'b0, d} >= MOD_EXT) ? MAX_CNT : d;
  endfunction

  function automatic logic at_end(input logic [WIDTH-1:0] q, input logic up);
    return up ? (q == MAX_CNT) : (q == '0);
  endfunction

  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    if (!LD_N) begin
      q_d = clamp_load(D);
    end else if (EN) begin
      if (at_end(q_q, UP)) begin
        ovf_d = 1'b1;
        if (!SAT) q_d = UP ? '0 : MAX_CNT;
      end else begin
        q_d = UP ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge CP or negedge RD_N) begin
    if (!RD_N) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign Q_N = ~q_q;
  assign OVF = ovf_q;
  assign TC  = EN & at_end(q_q, UP);

endmodule

// File: tb/tb_jk_updown_counter.sv
// Bench for jk_updown_counter: directed scenarios plus randomized runs against a
// behavioural integer model, on wrap (MOD=10), saturating (MOD=16) and cascaded instances.
module tb_jk_updown_counter;

  logic CP = 1'b0;
  logic rd_n;

  // Instance A: MOD=10, wrap
  logic       a_ld_n, a_en, a_up;
  logic [3:0] a_d, a_q, a_qn;
  logic       a_tc, a_ovf;
  // Instance B: MOD=16, saturate
  logic       b_ld_n, b_en, b_up;
  logic [3:0] b_d, b_q, b_qn;
  logic       b_tc, b_ovf;
  // Cascade: lo drives hi enable
  logic       c_ld_n, c_en, c_up;
  logic [3:0] c_dlo, c_dhi, lo_q, lo_qn, hi_q, hi_qn;
  logic       lo_tc, lo_ovf, hi_tc, hi_ovf;

  int checks = 0;
  int errors = 0;

  always #5 CP = ~CP;

  jk_updown_counter #(.WIDTH(4), .MOD(10), .SAT(1'b0)) u_a (
    .CP(CP), .RD_N(rd_n), .LD_N(a_ld_n), .EN(a_en), .UP(a_up), .D(a_d),
    .Q(a_q), .Q_N(a_qn), .TC(a_tc), .OVF(a_ovf));

  jk_updown_counter #(.WIDTH(4), .MOD(16), .SAT(1'b1)) u_b (
    .CP(CP), .RD_N(rd_n), .LD_N(b_ld_n), .EN(b_en), .UP(b_up), .D(b_d),
    .Q(b_q), .Q_N(b_qn), .TC(b_tc), .OVF(b_ovf));

  jk_updown_counter #(.WIDTH(4), .MOD(10), .SAT(1'b0)) u_lo (
    .CP(CP), .RD_N(rd_n), .LD_N(c_ld_n), .EN(c_en), .UP(c_up), .D(c_dlo),
    .Q(lo_q), .Q_N(lo_qn), .TC(lo_tc), .OVF(lo_ovf));

  jk_updown_counter #(.WIDTH(4), .MOD(10), .SAT(1'b0)) u_hi (
    .CP(CP), .RD_N(rd_n), .LD_N(c_ld_n), .EN(lo_tc), .UP(c_up), .D(c_dhi),
    .Q(hi_q), .Q_N(hi_qn), .TC(hi_tc), .OVF(hi_ovf));

  // Behavioural model: count value as a plain integer in 0..mod-1.
  function automatic int ref_next(input int mod, input bit sat, input int m,
                                  input bit ld_n, input bit en, input bit up,
                                  input int d, output bit ovf);
    ovf = 1'b0;
    if (!ld_n) return (d < mod) ? d : mod - 1;
    if (!en) return m;
    if (up) begin
      if (m + 1 < mod) return m + 1;
      ovf = 1'b1;
      return sat ? m : 0;
    end
    if (m > 0) return m - 1;
    ovf = 1'b1;
    return sat ? m : mod - 1;
  endfunction

  function automatic bit ref_tc(input int mod, input int m, input bit en, input bit up);
    return en && (up ? (m == mod - 1) : (m == 0));
  endfunction

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic test_reset();
    rd_n = 1'b0;
    a_ld_n = 1'b1; a_en = 1'b0; a_up = 1'b1; a_d = 4'd0;
    #3;
    checks++; if (a_q !== 4'd0 || a_qn !== 4'hF || a_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_init: q=%0d qn=%h ovf=%b want 0 F 0", a_q, a_qn, a_ovf); end
    rd_n = 1'b1;
    a_ld_n = 1'b0; a_d = 4'd7;
    tick();
    checks++; if (a_q !== 4'd7) begin errors++; $display("FAIL load7: got %0d want 7", a_q); end
    #3 rd_n = 1'b0;
    #1;
    checks++; if (a_q !== 4'd0 || a_qn !== 4'hF || a_ovf !== 1'b0) begin
      errors++; $display("FAIL async_clear: q=%0d qn=%h ovf=%b want 0 F 0", a_q, a_qn, a_ovf); end
    a_d = 4'd3; a_en = 1'b1;
    tick();
    checks++; if (a_q !== 4'd0) begin errors++; $display("FAIL edge_in_reset: got %0d want 0", a_q); end
    #2 rd_n = 1'b1;
    a_en = 1'b0; a_d = 4'd5;
    tick();
    checks++; if (a_q !== 4'd5 || a_qn !== 4'hA) begin
      errors++; $display("FAIL load_after_release: q=%0d qn=%h want 5 A", a_q, a_qn); end
  endtask

  task automatic test_up_wrap();
    a_ld_n = 1'b0; a_d = 4'd8; tick();
    a_ld_n = 1'b1; a_en = 1'b1; a_up = 1'b1; #1;
    checks++; if (a_tc !== 1'b0) begin errors++; $display("FAIL up_tc_at8: got %b want 0", a_tc); end
    tick();
    checks++; if (a_q !== 4'd9 || a_tc !== 1'b1 || a_ovf !== 1'b0) begin
      errors++; $display("FAIL up_to9: q=%0d tc=%b ovf=%b want 9 1 0", a_q, a_tc, a_ovf); end
    tick();
    checks++; if (a_q !== 4'd0 || a_ovf !== 1'b1) begin
      errors++; $display("FAIL up_wrap: q=%0d ovf=%b want 0 1", a_q, a_ovf); end
    tick();
    checks++; if (a_q !== 4'd1 || a_ovf !== 1'b0) begin
      errors++; $display("FAIL up_after_wrap: q=%0d ovf=%b want 1 0", a_q, a_ovf); end
  endtask

  task automatic test_down_wrap();
    a_ld_n = 1'b0; a_d = 4'd1; tick();
    a_ld_n = 1'b1; a_en = 1'b1; a_up = 1'b0;
    tick();
    checks++; if (a_q !== 4'd0 || a_tc !== 1'b1 || a_ovf !== 1'b0) begin
      errors++; $display("FAIL down_to0: q=%0d tc=%b ovf=%b want 0 1 0", a_q, a_tc, a_ovf); end
    tick();
    checks++; if (a_q !== 4'd9 || a_ovf !== 1'b1 || a_qn !== 4'h6) begin
      errors++; $display("FAIL down_wrap: q=%0d ovf=%b qn=%h want 9 1 6", a_q, a_ovf, a_qn); end
    a_up = 1'b1;
    tick();
    checks++; if (a_q !== 4'd0) begin errors++; $display("FAIL dir_change: got %0d want 0", a_q); end
  endtask

  task automatic test_saturation();
    b_ld_n = 1'b0; b_en = 1'b0; b_up = 1'b1; b_d = 4'd14; tick();
    b_ld_n = 1'b1; b_en = 1'b1;
    tick();
    checks++; if (b_q !== 4'd15 || b_ovf !== 1'b0 || b_tc !== 1'b1) begin
      errors++; $display("FAIL sat_1: q=%0d ovf=%b tc=%b want 15 0 1", b_q, b_ovf, b_tc); end
    tick();
    checks++; if (b_q !== 4'd15 || b_ovf !== 1'b1) begin
      errors++; $display("FAIL sat_2: q=%0d ovf=%b want 15 1", b_q, b_ovf); end
    tick();
    checks++; if (b_q !== 4'd15 || b_ovf !== 1'b1) begin
      errors++; $display("FAIL sat_3: q=%0d ovf=%b want 15 1", b_q, b_ovf); end
    b_up = 1'b0;
    tick();
    checks++; if (b_q !== 4'd14 || b_ovf !== 1'b0) begin
      errors++; $display("FAIL sat_down: q=%0d ovf=%b want 14 0", b_q, b_ovf); end
  endtask

  task automatic test_clamp_priority();
    a_ld_n = 1'b0; a_en = 1'b1; a_up = 1'b1; a_d = 4'd12;
    tick();
    checks++; if (a_q !== 4'd9 || a_ovf !== 1'b0) begin
      errors++; $display("FAIL clamp: q=%0d ovf=%b want 9 0", a_q, a_ovf); end
    a_ld_n = 1'b1; a_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (a_q !== 4'd9 || a_tc !== 1'b0 || a_ovf !== 1'b0) begin
        errors++; $display("FAIL hold_%0d: q=%0d tc=%b ovf=%b want 9 0 0", i, a_q, a_tc, a_ovf); end
    end
  endtask

  task automatic test_cascade();
    c_ld_n = 1'b0; c_en = 1'b0; c_up = 1'b1; c_dlo = 4'd9; c_dhi = 4'd9;
    tick();
    c_ld_n = 1'b1; c_en = 1'b1; #1;
    checks++; if (lo_tc !== 1'b1 || hi_tc !== 1'b1) begin
      errors++; $display("FAIL cascade_tc: lo=%b hi=%b want 1 1", lo_tc, hi_tc); end
    tick();
    checks++; if (lo_q !== 4'd0 || hi_q !== 4'd0 || lo_ovf !== 1'b1 || hi_ovf !== 1'b1) begin
      errors++; $display("FAIL cascade_wrap: lo=%0d hi=%0d ovf=%b%b want 0 0 11", lo_q, hi_q, lo_ovf, hi_ovf); end
    tick();
    checks++; if (lo_q !== 4'd1 || hi_q !== 4'd0 || lo_ovf !== 1'b0 || hi_ovf !== 1'b0) begin
      errors++; $display("FAIL cascade_next: lo=%0d hi=%0d ovf=%b%b want 1 0 00", lo_q, hi_q, lo_ovf, hi_ovf); end
  endtask

  // Random traffic on A (wrap) and B (saturate), including back-to-back loads and async resets.
  task automatic test_random(input bit use_b, input int n);
    int mod, m, d;
    bit sat, ovf_exp, ld_n, en, up;
    mod = use_b ? 16 : 10;
    sat = use_b;
    ld_n = 1'b0; en = 1'b0; up = 1'b1; d = 0;
    if (use_b) begin b_ld_n = 1'b0; b_d = 4'd0; end
    else begin a_ld_n = 1'b0; a_d = 4'd0; end
    tick();
    m = 0; ovf_exp = 1'b0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < 5) begin
        rd_n = 1'b0; #1;
        m = 0; ovf_exp = 1'b0;
        checks++; if ((use_b ? b_q : a_q) !== 4'd0) begin
          errors++; $display("FAIL rnd_reset[%0d]: got %0d want 0", i, use_b ? b_q : a_q); end
        rd_n = 1'b1; #1;
      end
      ld_n = ($urandom_range(99) >= 15);
      en   = ($urandom_range(99) < 75);
      up   = $urandom_range(1);
      d    = $urandom_range(15);
      if (use_b) begin b_ld_n = ld_n; b_en = en; b_up = up; b_d = 4'(d); end
      else begin a_ld_n = ld_n; a_en = en; a_up = up; a_d = 4'(d); end
      #1;
      checks++; if ((use_b ? b_tc : a_tc) !== ref_tc(mod, m, en, up)) begin
        errors++; $display("FAIL rnd_tc[%0d]: got %b want %b", i, use_b ? b_tc : a_tc, ref_tc(mod, m, en, up)); end
      m = ref_next(mod, sat, m, ld_n, en, up, d, ovf_exp);
      tick();
      checks++;
      if ((use_b ? b_q : a_q) !== 4'(m) || (use_b ? b_qn : a_qn) !== ~4'(m) ||
          (use_b ? b_ovf : a_ovf) !== ovf_exp) begin
        errors++;
        $display("FAIL rnd_state[%0d]: q=%0d qn=%h ovf=%b want %0d %h %b", i,
                 use_b ? b_q : a_q, use_b ? b_qn : a_qn, use_b ? b_ovf : a_ovf,
                 m, ~4'(m), ovf_exp);
      end
    end
    if (use_b) begin b_ld_n = 1'b1; b_en = 1'b0; end
    else begin a_ld_n = 1'b1; a_en = 1'b0; end
  endtask

  initial begin
    rd_n = 1'b0;
    a_ld_n = 1'b1; a_en = 1'b0; a_up = 1'b1; a_d = '0;
    b_ld_n = 1'b1; b_en = 1'b0; b_up = 1'b1; b_d = '0;
    c_ld_n = 1'b1; c_en = 1'b0; c_up = 1'b1; c_dlo = '0; c_dhi = '0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturation();
    test_clamp_priority();
    test_cascade();
    test_random(1'b0, 400);
    test_random(1'b1, 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
